// File: rtl/glyph_line_prefetch_ctrl.sv
`timescale 1ns/1ps
// glyph_line_prefetch_ctrl: button debounce, per-region glyph selectors, and a
// horizontal-blanking prefetch of the next glyph row into a ping-pong line buffer.
module glyph_line_prefetch_ctrl #(
    parameter int unsigned VTime     = 523,
    parameter int unsigned FontHTime = 150,
    parameter int unsigned DebCycles = 250000
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [3:0]           Letra,
    input  logic                 LineStart,
    input  logic [10:0]          Fila,
    input  logic [10:0]          Columna,
    output logic                 RomReq,
    output logic [13:0]          RomAddr,
    input  logic [FontHTime-1:0] RomData,
    input  logic                 RomValid,
    output logic                 Pixel,
    output logic [15:0]          Selector,
    output logic                 Busy,
    output logic                 Overrun
);

    localparam int unsigned N_GLYPH    = 4;
    localparam int unsigned ROW_W      = 11;
    localparam int unsigned COL_W      = 11;
    localparam int unsigned ADDR_ROW_W = 10;
    localparam int unsigned BIT_W      = $clog2(FontHTime);
    localparam int unsigned CNT_W      = $clog2(DebCycles + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Debounce state
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       armed;
    logic [3:0]       press_c;
    logic [CNT_W-1:0] deb_cnt [N_GLYPH];

    // Fetch state
    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [1:0]            idx;
    logic [1:0]            idx_nxt_c;
    logic [15:0]           snap;
    logic [ADDR_ROW_W-1:0] row;
    logic [ADDR_ROW_W-1:0] next_row_c;
    logic [ROW_W-1:0]      fila_inc_c;
    logic [3:0]            next_glyph_c;
    logic                  rom_done_c;
    logic                  front_sel;
    logic                  complete;
    logic [FontHTime-1:0]  line_buf [2][N_GLYPH];

    // Pixel lookup
    logic [COL_W-1:0] col_off_c;
    logic [1:0]       region_c;
    logic [BIT_W-1:0] bitpos_c;
    logic             pix_c;

    // A press fires on the DebCycles-th consecutive low sample of an armed button
    always_comb begin
        press_c = '0;
        for (int k = 0; k < N_GLYPH; k++) begin
            press_c[k] = armed[k] & ~sync2[k] & (deb_cnt[k] == CNT_W'(DebCycles - 1));
        end
    end

    // Synchronise buttons and count stable-low samples; re-arm on any high sample
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1 <= '1;
            sync2 <= '1;
            armed <= '0;
            for (int k = 0; k < N_GLYPH; k++) deb_cnt[k] <= '0;
        end else begin
            sync1 <= Letra;
            sync2 <= sync1;
            for (int k = 0; k < N_GLYPH; k++) begin
                if (sync2[k]) begin
                    deb_cnt[k] <= '0;
                    armed[k]   <= 1'b1;
                end else if (armed[k]) begin
                    if (press_c[k]) begin
                        deb_cnt[k] <= '0;
                        armed[k]   <= 1'b0;
                    end else begin
                        deb_cnt[k] <= deb_cnt[k] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Each accepted press advances its region's glyph selector, wrapping at 16
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Selector <= '0;
        end else begin
            for (int k = 0; k < N_GLYPH; k++) begin
                if (press_c[k]) Selector[k*4 +: 4] <= Selector[k*4 +: 4] + 4'd1;
            end
        end
    end

    // Row to prefetch, next glyph of the snapshot, and ROM completion strobe
    always_comb begin
        fila_inc_c   = Fila + ROW_W'(1);
        next_row_c   = (fila_inc_c == ROW_W'(VTime)) ? '0 : ADDR_ROW_W'(fila_inc_c);
        idx_nxt_c    = idx + 2'd1;
        next_glyph_c = snap[{idx_nxt_c, 2'b00} +: 4];
        rom_done_c   = (state == ST_WAIT) && RomValid;
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // FSM next state; LineStart always (re)starts the fetch at glyph 0
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: next_state = ST_IDLE;
            ST_REQ:  next_state = ST_WAIT;
            ST_WAIT: if (RomValid) next_state = (idx == 2'd3) ? ST_IDLE : ST_REQ;
            default: next_state = ST_IDLE;
        endcase
        if (LineStart) next_state = ST_REQ;
    end

    // Fetch datapath: snapshot, address generation, buffer writes, swap and overrun
    always_ff @(posedge Clk) begin
        if (Reset) begin
            RomReq    <= 1'b0;
            RomAddr   <= '0;
            Busy      <= 1'b0;
            Overrun   <= 1'b0;
            idx       <= '0;
            snap      <= '0;
            row       <= '0;
            front_sel <= 1'b0;
            complete  <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int g = 0; g < N_GLYPH; g++) line_buf[b][g] <= '0;
            end
        end else begin
            RomReq <= (next_state == ST_REQ);
            Busy   <= (next_state != ST_IDLE);
            if (LineStart) begin
                if (state != ST_IDLE) Overrun <= 1'b1;
                if (complete) front_sel <= ~front_sel;
                complete <= 1'b0;
                snap     <= Selector;
                row      <= next_row_c;
                idx      <= '0;
                RomAddr  <= {Selector[3:0], next_row_c};
            end else if (rom_done_c) begin
                line_buf[~front_sel][idx] <= RomData;
                if (idx == 2'd3) begin
                    complete <= 1'b1;
                end else begin
                    idx     <= idx_nxt_c;
                    RomAddr <= {next_glyph_c, row};
                end
            end
        end
    end

    // Locate region and bit within the front buffer for the current column
    always_comb begin
        col_off_c = Columna - COL_W'(FontHTime);
        region_c  = '0;
        bitpos_c  = '0;
        pix_c     = 1'b0;
        if ((Columna >= COL_W'(FontHTime)) && (Columna < COL_W'(5 * FontHTime)) &&
            (Fila < ROW_W'(VTime))) begin
            for (int r = 0; r < N_GLYPH; r++) begin
                if ((col_off_c >= COL_W'(r * FontHTime)) &&
                    (col_off_c < COL_W'((r + 1) * FontHTime))) begin
                    region_c = 2'(r);
                    bitpos_c = BIT_W'(col_off_c - COL_W'(r * FontHTime));
                end
            end
            pix_c = line_buf[front_sel][region_c][bitpos_c];
        end
    end

    // Registered video pixel
    always_ff @(posedge Clk) begin
        if (Reset) Pixel <= 1'b0;
        else       Pixel <= pix_c;
    end

endmodule
